i2s_mem_arbiter: RTL and testbench
==================================

I2S_MEM_ARBITER -- requirements
Module: i2s_mem_arbiter

Interface
REQ-001 SHALL have no parameters; the requester count is fixed at 2, indexed i = 0, 1.
REQ-002 SHALL have these ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-low reset
- enable  in  1  allows new grants
- reqN_request  in  1  per requester, one-cycle pulse asking for data
- reqN_size  in  24  per requester, words wanted, sampled on the reqN_request pulse
- reqN_strobe  out  1  per requester, qualifies reqN_data
- reqN_data  out  32  per requester, forwarded word
- reqN_finished  out  1  per requester, one-cycle completion pulse
- bufN_base  in  32  per requester, circular-buffer base word address
- bufN_len  in  24  per requester, circular-buffer length in words
- mem_read_start  out  1  one-cycle burst start pulse
- mem_address  out  32  burst start address
- mem_count  out  24  burst word count
- mem_data_strobe  in  1  qualifies mem_data
- mem_data  in  32  returned word

Function
REQ-003 SHALL latch a sticky pending[i] and size[i] on each reqN_request pulse; a pulse that arrives while pending[i] is already set SHALL be ignored.
REQ-004 SHALL keep a 24-bit offset[i] per requester, the read pointer into buffer i.
REQ-005 SHALL implement the states IDLE, ISSUE, XFER and FINISH.
REQ-006 IDLE: when enable=1 and any pending bit is set, SHALL grant a requester and go to ISSUE; while enable=0 it SHALL make no grant and SHALL clear both offsets.
REQ-007 Arbitration SHALL be round-robin:
- one requester pending: grant it
- both pending: grant the requester not granted last
- after reset, requester 0 has priority.
REQ-008 On grant, SHALL load remaining = size[g]; if remaining=0 or bufN_len=0, SHALL go straight to FINISH with no memory access.
REQ-009 ISSUE (one cycle): SHALL set chunk = min(remaining, bufN_len - offset[g]), drive mem_address = bufN_base + offset[g] and mem_count = chunk, pulse mem_read_start, then go to XFER.
REQ-010 mem_address and mem_count SHALL hold their values until the next ISSUE.
REQ-011 XFER: each mem_data_strobe SHALL:
- decrement chunk and remaining
- increment offset[g], wrapping to 0 when it reaches bufN_len.
REQ-012 XFER exit, on the strobe that makes chunk 0:
- remaining>0: go to ISSUE (split at buffer wrap)
- remaining=0: go to FINISH.
REQ-013 Forwarding SHALL be registered: mem_data_strobe at cycle T gives reqG_strobe=1 and reqG_data=mem_data at T+1; the non-granted requester's strobe SHALL stay 0.
REQ-014 FINISH (one cycle): SHALL pulse reqG_finished, clear pending[g], record g as last granted, and return to IDLE.
REQ-015 reqG_finished SHALL be asserted in the cycle after the last forwarded reqG_strobe.
REQ-016 A mem_data_strobe outside XFER SHALL be ignored.
REQ-017 Deasserting enable during ISSUE or XFER SHALL NOT abort the transfer; enable SHALL only gate new grants.
REQ-018 A reqN_request arriving in the same cycle as FINISH for the same requester SHALL be accepted as a new pending request.
REQ-019 All 24-bit arithmetic SHALL be unsigned; the 32-bit address SHALL wrap modulo 2^32.

Reset
REQ-020 rst=0 SHALL asynchronously force:
- state to IDLE
- pending, offsets and last-granted to 0
- mem_read_start, mem_address, mem_count, all reqN_strobe, reqN_data and reqN_finished to 0.
REQ-021 Reset release SHALL be synchronised to clk; the first grant SHALL come no earlier than the second clk edge after release.
REQ-022 Reset asserted mid-XFER SHALL discard the transfer, and no reqN_finished SHALL follow.

Verification
REQ-023 Single request:
- stimulus: buf0_base=0x100, buf0_len=16, req0 size=4
- required: one start pulse with address 0x100, count 4; 4 req0 strobes with data matching; req0_finished one cycle after the last strobe; offset0=4.
REQ-024 Wrap split:
- stimulus: offset0=14, len=16, size=4
- required: start (0x10E, count 2), then start (0x100, count 2); final offset0=2; exactly one finished pulse.
REQ-025 Contention:
- stimulus: req0 and req1 pulsed in the same cycle, then repeatedly re-requested
- required: grants alternate 0, 1, 0, 1; no requester's strobes are interleaved with the other's.
REQ-026 Zero cases:
- stimulus: size=0, and separately bufN_len=0
- required: no mem_read_start; finished pulses two cycles after grant.
REQ-027 Enable:
- stimulus: enable dropped mid-XFER
- required: transfer completes and finished pulses; a new request stays pending until enable=1; offsets are 0 after IDLE with enable=0.
REQ-028 Reset mid-transfer:
- stimulus: rst=0 after 2 of 4 strobes
- required: all outputs 0 immediately; no finished pulse; stray mem_data_strobe after release is ignored.

Source files
------------

// File: rtl/i2s_mem_arbiter.sv
// i2s_mem_arbiter: round-robin burst reader for two circular audio buffers.
// Bursts split at the buffer wrap; returned words go to the granted requester.
module i2s_mem_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        req0_request,
   input  logic [23:0] req0_size,
   output logic        req0_strobe,
   output logic [31:0] req0_data,
   output logic        req0_finished,
   input  logic [31:0] buf0_base,
   input  logic [23:0] buf0_len,
   input  logic        req1_request,
   input  logic [23:0] req1_size,
   output logic        req1_strobe,
   output logic [31:0] req1_data,
   output logic        req1_finished,
   input  logic [31:0] buf1_base,
   input  logic [23:0] buf1_len,
   output logic        mem_read_start,
   output logic [31:0] mem_address,
   output logic [23:0] mem_count,
   input  logic        mem_data_strobe,
   input  logic [31:0] mem_data
);

   typedef enum logic [1:0] {IDLE, ISSUE, XFER, FINISH} state_t;

   state_t      state;
   logic [1:0]  run_sync;
   logic [1:0]  pending;
   logic [1:0]  last_gnt;
   logic        gnt;
   logic [23:0] size_q [2];
   logic [23:0] offset [2];
   logic [23:0] remaining;
   logic [23:0] chunk;
   logic [1:0]  strobe_q;
   logic [1:0]  finished_q;
   logic [31:0] data_q [2];

   logic [1:0]  request;
   logic [23:0] req_size [2];
   logic [31:0] buf_base [2];
   logic [23:0] buf_len  [2];

   logic [31:0] cur_base;
   logic [23:0] cur_len;
   logic [23:0] cur_off;
   logic [23:0] space;
   logic [23:0] first_chunk;
   logic [23:0] next_off;
   logic        pick;
   logic        can_grant;
   logic [1:0]  accept;

   assign request     = {req1_request, req0_request};
   assign req_size[0] = req0_size;
   assign req_size[1] = req1_size;
   assign buf_base[0] = buf0_base;
   assign buf_base[1] = buf1_base;
   assign buf_len[0]  = buf0_len;
   assign buf_len[1]  = buf1_len;

   assign req0_strobe   = strobe_q[0];
   assign req1_strobe   = strobe_q[1];
   assign req0_data     = data_q[0];
   assign req1_data     = data_q[1];
   assign req0_finished = finished_q[0];
   assign req1_finished = finished_q[1];

   always_comb begin
      cur_base    = buf_base[gnt];
      cur_len     = buf_len[gnt];
      cur_off     = offset[gnt];
      space       = cur_len - cur_off;
      first_chunk = (remaining < space) ? remaining : space;
      next_off    = ({1'b0, cur_off} + 25'd1 >= {1'b0, cur_len}) ?
                    24'd0 : cur_off + 24'd1;
      // last_gnt is one-hot; zero after reset so requester 0 wins a tie
      pick        = pending[0] ? (pending[1] & last_gnt[0]) : 1'b1;
      can_grant   = run_sync[1] & enable & (|pending);
      accept[0]   = request[0] & (~pending[0] | (state == FINISH && !gnt));
      accept[1]   = request[1] & (~pending[1] | (state == FINISH && gnt));
   end

   // release is synchronised; grants wait for the second stage
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) run_sync <= 2'b00;
      else      run_sync <= {run_sync[0], 1'b1};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         pending        <= 2'b00;
         last_gnt       <= 2'b00;
         gnt            <= 1'b0;
         size_q[0]      <= '0;
         size_q[1]      <= '0;
         offset[0]      <= '0;
         offset[1]      <= '0;
         remaining      <= '0;
         chunk          <= '0;
         mem_read_start <= 1'b0;
         mem_address    <= '0;
         mem_count      <= '0;
         strobe_q       <= 2'b00;
         finished_q     <= 2'b00;
         data_q[0]      <= '0;
         data_q[1]      <= '0;
      end else begin
         mem_read_start <= 1'b0;
         strobe_q       <= 2'b00;
         finished_q     <= 2'b00;
         unique case (state)
            IDLE: begin
               if (!enable) begin
                  offset[0] <= '0;
                  offset[1] <= '0;
               end
               if (can_grant) begin
                  gnt       <= pick;
                  remaining <= size_q[pick];
                  if (size_q[pick] == '0 || buf_len[pick] == '0)
                     state <= FINISH;
                  else
                     state <= ISSUE;
               end
            end
            ISSUE: begin
               chunk          <= first_chunk;
               mem_address    <= cur_base + {8'd0, cur_off};
               mem_count      <= first_chunk;
               mem_read_start <= 1'b1;
               state          <= XFER;
            end
            XFER: begin
               if (mem_data_strobe) begin
                  chunk         <= chunk - 24'd1;
                  remaining     <= remaining - 24'd1;
                  offset[gnt]   <= next_off;
                  strobe_q[gnt] <= 1'b1;
                  data_q[gnt]   <= mem_data;
                  if (chunk == 24'd1) begin
                     if (remaining == 24'd1) state <= FINISH;
                     else                    state <= ISSUE;
                  end
               end
            end
            FINISH: begin
               finished_q[gnt] <= 1'b1;
               pending[gnt]    <= 1'b0;
               last_gnt        <= gnt ? 2'b10 : 2'b01;
               state           <= IDLE;
            end
            default: state <= IDLE;
         endcase
         // placed last so a re-request during FINISH survives the clear
         for (int i = 0; i < 2; i++) begin
            if (accept[i]) begin
               pending[i] <= 1'b1;
               size_q[i]  <= req_size[i];
            end
         end
      end
   end

endmodule

// File: tb/tb_i2s_mem_arbiter.sv
// Bench for i2s_mem_arbiter: directed and random transfers checked
// against a transaction-level model of grants, bursts and words.
module tb_i2s_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        req0_request, req1_request;
   logic [23:0] req0_size, req1_size;
   logic        req0_strobe, req1_strobe;
   logic [31:0] req0_data, req1_data;
   logic        req0_finished, req1_finished;
   logic [31:0] buf0_base, buf1_base;
   logic [23:0] buf0_len, buf1_len;
   logic        mem_read_start;
   logic [31:0] mem_address;
   logic [23:0] mem_count;
   logic        mem_data_strobe;
   logic [31:0] mem_data;

   always #5 clk = ~clk;

   i2s_mem_arbiter dut (
      .clk(clk), .rst(rst), .enable(enable),
      .req0_request(req0_request), .req0_size(req0_size),
      .req0_strobe(req0_strobe), .req0_data(req0_data),
      .req0_finished(req0_finished),
      .buf0_base(buf0_base), .buf0_len(buf0_len),
      .req1_request(req1_request), .req1_size(req1_size),
      .req1_strobe(req1_strobe), .req1_data(req1_data),
      .req1_finished(req1_finished),
      .buf1_base(buf1_base), .buf1_len(buf1_len),
      .mem_read_start(mem_read_start), .mem_address(mem_address),
      .mem_count(mem_count),
      .mem_data_strobe(mem_data_strobe), .mem_data(mem_data)
   );

   typedef struct { logic [31:0] addr; logic [23:0] cnt; } burst_t;
   typedef struct { bit g; logic [31:0] data; bit last; } word_t;
   typedef struct { bit g; bit has_words; int fin_at; logic [31:0] addr; } fin_t;

   burst_t      exp_burst[$];
   word_t       exp_word[$];
   fin_t        exp_fin[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          off_m [2];
   int          last_m = -1;
   logic [31:0] last_addr_m = '0;
   logic [31:0] key;
   logic [31:0] resp_addr;
   int          resp_left = 0;
   bit          stray_force = 0;
   int          activity = 0;
   int          starts = 0;
   int          words_seen = 0;
   int          last_strobe_cyc = 0;
   bit          last_word_seen [2];

   function automatic logic [31:0] word(input logic [31:0] a);
      return a ^ key ^ {a[15:0], a[31:16]};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Model: a transfer reads size words starting at the read pointer,
   // one burst per contiguous run up to the buffer end.
   task automatic expect_xfer(input bit g, input int size, input int fin_at);
      logic [31:0] base;
      int len, o, rem, c;
      burst_t b;
      word_t w;
      fin_t f;
      base = g ? buf1_base : buf0_base;
      len  = int'(g ? buf1_len : buf0_len);
      o    = off_m[g];
      rem  = (len == 0) ? 0 : size;
      f.has_words = (rem > 0);
      while (rem > 0) begin
         c = (rem < len - o) ? rem : len - o;
         b.addr = base + 32'(o);
         b.cnt  = 24'(c);
         exp_burst.push_back(b);
         last_addr_m = b.addr;
         for (int k = 0; k < c; k++) begin
            w.g    = g;
            w.data = word(base + 32'(o + k));
            w.last = (rem == c) && (k == c - 1);
            exp_word.push_back(w);
         end
         rem -= c;
         o = (o + c) % len;
      end
      off_m[g] = o;
      f.g      = g;
      f.fin_at = fin_at;
      f.addr   = last_addr_m;
      exp_fin.push_back(f);
      last_m = g;
   endtask

   task automatic take_word(input bit i, input logic [31:0] d);
      word_t w;
      activity++;
      check("strobe_expected", exp_word.size() != 0, 1);
      if (exp_word.size() == 0) return;
      w = exp_word.pop_front();
      check("strobe_owner", i, w.g);
      check("strobe_data", d, w.data);
      words_seen++;
      if (w.last) begin
         last_strobe_cyc = cyc;
         last_word_seen[i] = 1;
      end
   endtask

   task automatic take_fin(input bit i);
      fin_t f;
      activity++;
      check("finish_expected", exp_fin.size() != 0, 1);
      if (exp_fin.size() == 0) return;
      f = exp_fin.pop_front();
      check("finish_owner", i, f.g);
      if (f.has_words) check("finish_after_last", cyc, last_strobe_cyc + 1);
      if (f.fin_at != 0) check("finish_latency", cyc, f.fin_at);
      check("addr_hold", mem_address, f.addr);
   endtask

   task automatic take_burst();
      burst_t b;
      activity++;
      starts++;
      check("start_expected", exp_burst.size() != 0, 1);
      resp_addr = mem_address;
      resp_left = int'(mem_count);
      if (exp_burst.size() == 0) return;
      b = exp_burst.pop_front();
      check("start_addr", mem_address, b.addr);
      check("start_count", mem_count, b.cnt);
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      req0_request = 0;
      req1_request = 0;
      if (req0_strobe) take_word(0, req0_data);
      if (req1_strobe) take_word(1, req1_data);
      if (req0_strobe || req1_strobe)
         check("single_strobe", req0_strobe & req1_strobe, 0);
      if (mem_read_start) take_burst();
      if (req0_finished) take_fin(0);
      if (req1_finished) take_fin(1);
      if (resp_left > 0 && $urandom_range(3) != 0) begin
         mem_data_strobe = 1;
         mem_data = word(resp_addr);
         resp_addr++;
         resp_left--;
      end else if (stray_force || (resp_left == 0 && $urandom_range(7) == 0)) begin
         mem_data_strobe = 1;
         mem_data = $urandom;
      end else begin
         mem_data_strobe = 0;
         mem_data = $urandom;
      end
   endtask

   task automatic pulse(input bit g, input int size);
      if (g) begin req1_request = 1; req1_size = 24'(size); end
      else   begin req0_request = 1; req0_size = 24'(size); end
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while ((exp_fin.size() + exp_word.size() + exp_burst.size()) != 0
             && n < budget) begin
         tick();
         n++;
      end
      check("drain", exp_fin.size() + exp_word.size() + exp_burst.size(), 0);
      tick();
      tick();
   endtask

   task automatic wait_words(input int target, input int budget);
      int n = 0;
      while (words_seen < target && n < budget) begin tick(); n++; end
      check("words_reached", words_seen >= target, 1);
   endtask

   task automatic wait_last(input bit g, input int budget);
      int n = 0;
      while (!last_word_seen[g] && n < budget) begin tick(); n++; end
      check("last_word_wait", last_word_seen[g], 1);
      last_word_seen[g] = 0;
   endtask

   task automatic check_quiet_outputs(input string tag);
      check({tag, "_start"}, mem_read_start, 0);
      check({tag, "_addr"}, mem_address, 0);
      check({tag, "_count"}, mem_count, 0);
      check({tag, "_strobes"}, {req1_strobe, req0_strobe}, 0);
      check({tag, "_data"}, {req1_data, req0_data}, 0);
      check({tag, "_fin"}, {req1_finished, req0_finished}, 0);
   endtask

   task automatic model_reset();
      exp_burst.delete();
      exp_word.delete();
      exp_fin.delete();
      resp_left = 0;
      off_m[0] = 0;
      off_m[1] = 0;
      last_m = -1;
      last_addr_m = '0;
   endtask

   initial begin
      bit first, x;
      int s0, s1, a0, r, n, mode;
      key = $urandom;
      rst = 1; enable = 1;
      req0_request = 0; req1_request = 0;
      req0_size = '0; req1_size = '0;
      mem_data_strobe = 0; mem_data = '0;
      buf0_base = 32'h100; buf0_len = 24'd16;
      buf1_base = 32'h2000; buf1_len = 24'd10;
      off_m[0] = 0; off_m[1] = 0;
      last_word_seen[0] = 0; last_word_seen[1] = 0;
      #1 rst = 0;
      #1 check_quiet_outputs("reset");
      repeat (2) tick();
      rst = 1;
      repeat (4) tick();

      // single request, then run the pointer up to 14
      pulse(0, 4); expect_xfer(0, 4, 0); wait_done(200);
      pulse(0, 10); expect_xfer(0, 10, 0); wait_done(200);
      // wrap split: 0x10E x2 then 0x100 x2, pointer ends at 2
      pulse(0, 4); expect_xfer(0, 4, 0); wait_done(200);
      pulse(0, 1); expect_xfer(0, 1, 0); wait_done(200);

      // zero size and zero length
      a0 = starts;
      pulse(0, 0); expect_xfer(0, 0, cyc + 3); wait_done(50);
      buf1_len = 24'd0;
      pulse(1, 5); expect_xfer(1, 5, cyc + 3); wait_done(50);
      buf1_len = 24'd10;
      check("zero_no_start", starts - a0, 0);

      // contention with re-requests landing in the FINISH cycle
      last_word_seen[0] = 0; last_word_seen[1] = 0;
      first = (last_m == 0);
      s0 = $urandom_range(2, 7); s1 = $urandom_range(2, 7);
      pulse(first, s0); pulse(!first, s1);
      expect_xfer(first, s0, 0); expect_xfer(!first, s1, 0);
      for (int k = 0; k < 4; k++) begin
         x = (k % 2 == 0) ? first : !first;
         wait_last(x, 300);
         s0 = $urandom_range(1, 6);
         pulse(x, s0);
         expect_xfer(x, s0, 0);
      end
      wait_done(400);

      // both pending while disabled, released together
      enable = 0;
      first = (last_m == 0);
      pulse(0, 3); pulse(1, 3);
      repeat (5) tick();
      off_m[0] = 0; off_m[1] = 0;
      enable = 1;
      expect_xfer(first, 3, 0); expect_xfer(!first, 3, 0);
      wait_done(300);

      // enable dropped mid-transfer
      pulse(1, 6); expect_xfer(1, 6, 0);
      wait_words(words_seen + 2, 200);
      enable = 0;
      pulse(0, 3);
      wait_done(200);
      a0 = starts;
      repeat (10) tick();
      check("disabled_no_grant", starts - a0, 0);
      off_m[0] = 0; off_m[1] = 0;
      enable = 1;
      expect_xfer(0, 3, 0); wait_done(200);
      pulse(1, 2); expect_xfer(1, 2, 0); wait_done(200);

      // reset after two of four words
      pulse(0, 4); expect_xfer(0, 4, 0);
      wait_words(words_seen + 2, 200);
      rst = 0;
      #1 check_quiet_outputs("midreset");
      model_reset();
      a0 = activity;
      repeat (3) tick();
      rst = 1;
      stray_force = 1;
      repeat (6) tick();
      stray_force = 0;
      repeat (2) tick();
      check("no_activity_after_reset", activity - a0, 0);

      // grant after release needs two synchronising edges
      rst = 0;
      model_reset();
      tick();
      rst = 1;
      pulse(1, 3); expect_xfer(1, 3, 0);
      r = cyc; a0 = starts; n = 0;
      while (starts == a0 && n < 50) begin tick(); n++; end
      check("release_start_delay", cyc >= r + 3, 1);
      wait_done(200);

      // randomized traffic, second buffer straddles 2^32
      buf0_base = $urandom;
      buf0_len  = 24'($urandom_range(1, 12));
      buf1_base = 32'hFFFF_FFFA;
      buf1_len  = 24'($urandom_range(4, 12));
      for (int t = 0; t < 30; t++) begin
         mode = $urandom_range(2);
         s0 = ($urandom_range(4) == 0) ? 0 : $urandom_range(1, 20);
         s1 = ($urandom_range(4) == 0) ? 0 : $urandom_range(1, 20);
         if (mode == 0) begin
            pulse(0, s0); expect_xfer(0, s0, (s0 == 0) ? cyc + 3 : 0);
         end else if (mode == 1) begin
            pulse(1, s1); expect_xfer(1, s1, (s1 == 0) ? cyc + 3 : 0);
         end else begin
            first = (last_m == 0);
            pulse(0, s0); pulse(1, s1);
            expect_xfer(first, first ? s1 : s0, 0);
            expect_xfer(!first, first ? s0 : s1, 0);
         end
         wait_done(600);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
